block_lock_64b66b: RTL and testbench
====================================

# block_lock_64b66b

Receive-side 64b/66b block synchronizer for the 40G/100G PCS, sitting directly upstream of the 64-bit descrambler. It takes 66-bit blocks from the RX gearbox and checks sync headers to acquire and hold block lock. While unlocked it issues slip requests back to the gearbox. While locked it forwards the 64-bit scrambled payload and its header, registered, to the descrambler.

## Interface
- SH_CNT_MAX, 64: sync headers tested per window.
- SH_INVLD_MAX, 16: invalid headers within one window that drop lock.
- SLIP_WAIT_CYC, 4: CLK cycles to ignore input after a slip pulse, for gearbox settling; must be ≥1.
- CLK  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- blk_in  in  66  [1:0] sync header, [65:2] scrambled payload.
- blk_valid  in  1  blk_in holds a new block this cycle.
- slip  out  1  one-cycle pulse; gearbox shifts block boundary by one bit.
- block_lock  out  1  header alignment acquired.
- data_out  out  64  blk_in[65:2], in bit order unchanged; drives descrambler Sr_In.
- hdr_out  out  2  blk_in[1:0] of the forwarded block.
- data_valid  out  1  data_out/hdr_out qualify.
- hdr_err  out  1  forwarded block carried an invalid header.

## Operation
- A header is valid iff it is 2'b01 (data) or 2'b10 (control).
- FSM states: HUNT, LOCKED, SLIP_WAIT. Reset enters HUNT.
- Counters: sh_cnt, width $clog2(SH_CNT_MAX+1); sh_invld_cnt, width $clog2(SH_INVLD_MAX+1); wait_cnt. All three clear on reset.
- Blocks are tested only when blk_valid=1. When blk_valid=0, the state and all counters hold.
- HUNT behaviour:
  - A valid header increments sh_cnt.
  - Any invalid header moves to SLIP_WAIT, pulses slip and clears both header counters.
  - When sh_cnt reaches SH_CNT_MAX, move to LOCKED, set block_lock=1 and clear both header counters.
- LOCKED behaviour:
  - Every tested header increments sh_cnt. An invalid header also increments sh_invld_cnt.
  - When sh_invld_cnt reaches SH_INVLD_MAX, move to SLIP_WAIT, clear block_lock and pulse slip.
  - Otherwise, when sh_cnt reaches SH_CNT_MAX, clear both header counters and stay LOCKED.
  - If both counters reach their maximum on the same block, the invalid limit wins: lock is lost.
- SLIP_WAIT behaviour:
  - Input is ignored and slip is held low after its first cycle.
  - wait_cnt counts SLIP_WAIT_CYC cycles, independent of blk_valid.
  - The FSM then returns to HUNT with all counters zero.
- Forwarding: on every cycle with blk_valid=1 and block_lock=1 (registered value, before this cycle's update):
  - data_out←blk_in[65:2], hdr_out←blk_in[1:0], data_valid←1.
  - hdr_err←1 if the header is invalid.
  - Otherwise data_valid←0 and hdr_err←0; data_out and hdr_out hold.
  - The block that causes lock loss is still forwarded, with hdr_err=1.

## Timing
- Reset values: slip=0, block_lock=0, data_out=0, hdr_out=0, data_valid=0, hdr_err=0.
- Forwarding latency is 1 cycle from blk_in/blk_valid to data_out/data_valid.
- block_lock rises on the edge that samples the SH_CNT_MAX-th consecutive valid header. The next valid block is the first one forwarded.
- block_lock falls on the edge that samples the SH_INVLD_MAX-th invalid header in a window.
- slip is high for exactly the cycle after the triggering edge. Minimum spacing between slip pulses is SLIP_WAIT_CYC+1 cycles.
- Asserting reset mid-operation returns the block to HUNT and forces all outputs low on the next edge. No slip is issued.

## Structure
- The shared package pcs_pkg holds:
  - SH_DATA=2'b01 and SH_CTRL=2'b10;
  - the block-lock state enum {HUNT, LOCKED, SLIP_WAIT};
  - a 66-bit block typedef, with a 2-bit header field and a 64-bit payload field.
- No sub-module. The FSM, counters and output register live in one module.
- The top-level RX path instantiates this block and feeds data_out into Descrambler_64bit.

## Test plan
- Reset, then 64 consecutive blocks with header 2'b01 → block_lock=1 after the 64th; block 65 appears on data_out one cycle later with data_valid=1 and hdr_err=0.
- From reset, 10 valid headers then one header 2'b00 → one slip pulse; no second slip for 4 cycles; sh_cnt restarts from 0; block_lock stays 0.
- While locked, 15 headers 2'b11 spread within one 64-header window → lock held, with hdr_err=1 on those 15 outputs. A 16th invalid header in the same window → block_lock=0 and a slip pulse.
- While locked, 15 invalid headers in window N, then the window rolls over, then 15 invalid in window N+1 → lock never lost.
- Invalid header on the 64th header of a window that already has 15 invalid → lock lost, not a counter reset.
- Reset pulled low while locked and blk_valid toggling → all outputs 0 next cycle, no slip. Re-locking needs 64 fresh valid headers.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared 40G/100G PCS definitions: sync-header codes, block-lock FSM states
// and the 66-bit block layout as delivered by the RX gearbox.
package pcs_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        LOCKED    = 2'd1,
        SLIP_WAIT = 2'd2
    } lock_state_t;

    // Header sits in the low two bits, matching blk_in[1:0].
    typedef struct packed {
        logic [63:0] payload;
        logic [1:0]  hdr;
    } block_t;

    function automatic logic sh_valid(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_lock_64b66b.sv
// 64b/66b RX block synchronizer: hunts for sync-header alignment with gearbox
// slips, holds lock with a windowed invalid-header count, forwards payload.
import pcs_pkg::*;

module block_lock_64b66b #(
    parameter int SH_CNT_MAX    = 64,
    parameter int SH_INVLD_MAX  = 16,
    parameter int SLIP_WAIT_CYC = 4
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [65:0] blk_in,
    input  logic        blk_valid,
    output logic        slip,
    output logic        block_lock,
    output logic [63:0] data_out,
    output logic [1:0]  hdr_out,
    output logic        data_valid,
    output logic        hdr_err,
    output logic [1:0]  fsm_state
);

    localparam int SW = $clog2(SH_CNT_MAX + 1);
    localparam int IW = $clog2(SH_INVLD_MAX + 1);
    localparam int WW = $clog2(SLIP_WAIT_CYC + 1);

    localparam logic [SW-1:0] SH_LAST   = SW'(SH_CNT_MAX - 1);
    localparam logic [SW-1:0] SH_ONE    = SW'(1);
    localparam logic [IW-1:0] INV_LAST  = IW'(SH_INVLD_MAX - 1);
    localparam logic [IW-1:0] INV_ONE   = IW'(1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT_CYC - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

    lock_state_t   state, state_n;
    logic [SW-1:0] sh_cnt, sh_cnt_n;
    logic [IW-1:0] sh_invld_cnt, sh_invld_cnt_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic          lock_n, slip_n;
    block_t        blk;
    logic          hdr_ok;

    assign blk       = block_t'(blk_in);
    assign hdr_ok    = sh_valid(blk.hdr);
    assign fsm_state = state;

    // Counters are compared against max-1 so the transition fires on the
    // edge that samples the limiting header, not one block later.
    always_comb begin
        state_n        = state;
        sh_cnt_n       = sh_cnt;
        sh_invld_cnt_n = sh_invld_cnt;
        wait_cnt_n     = wait_cnt;
        lock_n         = block_lock;
        slip_n         = 1'b0;
        case (state)
            HUNT: begin
                if (blk_valid) begin
                    if (!hdr_ok) begin
                        state_n        = SLIP_WAIT;
                        slip_n         = 1'b1;
                        sh_cnt_n       = '0;
                        sh_invld_cnt_n = '0;
                    end else if (sh_cnt == SH_LAST) begin
                        state_n        = LOCKED;
                        lock_n         = 1'b1;
                        sh_cnt_n       = '0;
                        sh_invld_cnt_n = '0;
                    end else begin
                        sh_cnt_n = sh_cnt + SH_ONE;
                    end
                end
            end
            LOCKED: begin
                if (blk_valid) begin
                    // Invalid limit is checked first so it wins a tie with window end.
                    if (!hdr_ok && (sh_invld_cnt == INV_LAST)) begin
                        state_n        = SLIP_WAIT;
                        lock_n         = 1'b0;
                        slip_n         = 1'b1;
                        sh_cnt_n       = '0;
                        sh_invld_cnt_n = '0;
                    end else if (sh_cnt == SH_LAST) begin
                        sh_cnt_n       = '0;
                        sh_invld_cnt_n = '0;
                    end else begin
                        sh_cnt_n = sh_cnt + SH_ONE;
                        if (!hdr_ok) begin
                            sh_invld_cnt_n = sh_invld_cnt + INV_ONE;
                        end
                    end
                end
            end
            SLIP_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_n    = HUNT;
                    wait_cnt_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_ONE;
                end
            end
            default: begin
                state_n = HUNT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state        <= HUNT;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            wait_cnt     <= '0;
            block_lock   <= 1'b0;
            slip         <= 1'b0;
        end else begin
            state        <= state_n;
            sh_cnt       <= sh_cnt_n;
            sh_invld_cnt <= sh_invld_cnt_n;
            wait_cnt     <= wait_cnt_n;
            block_lock   <= lock_n;
            slip         <= slip_n;
        end
    end

    // Forwarding qualifies on the registered lock, so the locking block is
    // not forwarded but the block that loses lock still is.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            data_out   <= '0;
            hdr_out    <= '0;
            data_valid <= 1'b0;
            hdr_err    <= 1'b0;
        end else if (blk_valid && block_lock) begin
            data_out   <= blk.payload;
            hdr_out    <= blk.hdr;
            data_valid <= 1'b1;
            hdr_err    <= !hdr_ok;
        end else begin
            data_valid <= 1'b0;
            hdr_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_block_lock_64b66b.sv
// Self-checking bench for block_lock_64b66b: directed lock/slip scenarios and
// random traffic, every cycle compared against a behavioural model.
module tb_block_lock_64b66b;

    localparam int SH_CNT_MAX    = 64;
    localparam int SH_INVLD_MAX  = 16;
    localparam int SLIP_WAIT_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [65:0] blk_in;
    logic        blk_valid;
    logic        slip;
    logic        block_lock;
    logic [63:0] data_out;
    logic [1:0]  hdr_out;
    logic        data_valid;
    logic        hdr_err;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: plain counts of headers seen, not the RTL encoding
    bit          m_locked;
    int          m_good_run;
    int          m_window_seen;
    int          m_window_bad;
    int          m_wait_left;
    logic        e_slip, e_dv, e_err;
    logic [63:0] e_data;
    logic [1:0]  e_hdr;

    always #5 clk = ~clk;

    block_lock_64b66b #(
        .SH_CNT_MAX   (SH_CNT_MAX),
        .SH_INVLD_MAX (SH_INVLD_MAX),
        .SLIP_WAIT_CYC(SLIP_WAIT_CYC)
    ) dut (
        .CLK       (clk),
        .rst       (rst_n),
        .blk_in    (blk_in),
        .blk_valid (blk_valid),
        .slip      (slip),
        .block_lock(block_lock),
        .data_out  (data_out),
        .hdr_out   (hdr_out),
        .data_valid(data_valid),
        .hdr_err   (hdr_err),
        .fsm_state (fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_good_run = 0; m_window_seen = 0; m_window_bad = 0;
        m_wait_left = 0;
        e_slip = 0; e_dv = 0; e_err = 0; e_data = '0; e_hdr = '0;
    endtask

    task automatic model_step(input bit r, input bit v, input logic [65:0] b);
        bit ok;
        ok = (b[1:0] == 2'b01) || (b[1:0] == 2'b10);
        if (!r) begin
            model_reset();
            return;
        end
        e_slip = 0;
        if (v && m_locked) begin
            e_dv = 1; e_err = !ok; e_data = b[65:2]; e_hdr = b[1:0];
        end else begin
            e_dv = 0; e_err = 0;
        end
        if (m_wait_left > 0) begin
            m_wait_left--;
        end else if (v) begin
            if (!m_locked) begin
                if (ok) begin
                    m_good_run++;
                    if (m_good_run == SH_CNT_MAX) begin
                        m_locked = 1; m_good_run = 0;
                        m_window_seen = 0; m_window_bad = 0;
                    end
                end else begin
                    e_slip = 1; m_wait_left = SLIP_WAIT_CYC; m_good_run = 0;
                end
            end else begin
                m_window_seen++;
                if (!ok) m_window_bad++;
                if (m_window_bad == SH_INVLD_MAX) begin
                    m_locked = 0; e_slip = 1; m_wait_left = SLIP_WAIT_CYC;
                    m_window_seen = 0; m_window_bad = 0; m_good_run = 0;
                end else if (m_window_seen == SH_CNT_MAX) begin
                    m_window_seen = 0; m_window_bad = 0;
                end
            end
        end
    endtask

    // drive one cycle, advance the model on the same edge, compare #1 later
    task automatic step(input bit r, input bit v, input logic [1:0] hdr);
        logic [65:0] b;
        b = {$urandom(), $urandom(), hdr};
        rst_n = r; blk_valid = v; blk_in = b;
        @(posedge clk);
        model_step(r, v, b);
        #1;
        check("slip",       64'(slip),       64'(e_slip));
        check("block_lock", 64'(block_lock), 64'(m_locked));
        check("data_valid", 64'(data_valid), 64'(e_dv));
        check("hdr_err",    64'(hdr_err),    64'(e_err));
        check("data_out",   data_out,        e_data);
        check("hdr_out",    64'(hdr_out),    64'(e_hdr));
    endtask

    task automatic lock_up();
        for (int i = 0; i < SH_CNT_MAX; i++) step(1, 1, good_hdr());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 2'b00);
    endtask

    // one locked window of 64 headers with n_bad invalids spread every 4th slot
    task automatic window_with_bad(input int n_bad, input bit last_bad);
        int placed;
        placed = 0;
        for (int i = 0; i < SH_CNT_MAX; i++) begin
            if (i == SH_CNT_MAX - 1 && last_bad) step(1, 1, bad_hdr());
            else if ((i % 4 == 1) && placed < n_bad) begin
                step(1, 1, bad_hdr()); placed++;
            end else step(1, 1, good_hdr());
        end
    endtask

    initial begin
        model_reset();
        rst_n = 0; blk_valid = 0; blk_in = '0;

        // reset values
        for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 1), good_hdr());
        check("reset_lock", 64'(block_lock), 64'(0));
        check("reset_slip", 64'(slip), 64'(0));

        // acquire lock, first forwarded block is the 65th
        lock_up();
        check("lock_after_64", 64'(block_lock), 64'(1));
        step(1, 1, 2'b01);
        check("first_fwd_valid", 64'(data_valid), 64'(1));

        // 15 invalid per window over two windows: lock held
        window_with_bad(15, 0);
        window_with_bad(15, 0);
        check("lock_held_15", 64'(block_lock), 64'(1));

        // 16th invalid within a window drops lock
        window_with_bad(16, 0);
        check("lock_lost_16", 64'(block_lock), 64'(0));
        idle(SLIP_WAIT_CYC + 2);

        // 15 invalid plus an invalid 64th header: lock lost, not a rollover
        lock_up();
        for (int i = 0; i < SH_CNT_MAX - 1; i++)
            step(1, 1, (i % 4 == 1 && i < 60) ? bad_hdr() : good_hdr());
        step(1, 1, 2'b11);
        check("tie_slip", 64'(slip), 64'(1));
        check("tie_lock", 64'(block_lock), 64'(0));
        idle(SLIP_WAIT_CYC + 2);

        // hunting: 10 good then 2'b00 slips, then header run restarts
        step(0, 0, 2'b00);
        for (int i = 0; i < 10; i++) step(1, 1, good_hdr());
        step(1, 1, 2'b00);
        check("hunt_slip", 64'(slip), 64'(1));
        for (int i = 0; i < SLIP_WAIT_CYC; i++) step(1, 1, bad_hdr());
        for (int i = 0; i < SH_CNT_MAX - 1; i++) step(1, 1, good_hdr());
        check("no_early_lock", 64'(block_lock), 64'(0));
        step(1, 1, good_hdr());
        check("relock_64", 64'(block_lock), 64'(1));

        // reset while locked and blk_valid toggling
        for (int i = 0; i < 4; i++) step(0, i[0], good_hdr());
        check("rst_lock", 64'(block_lock), 64'(0));
        check("rst_dv", 64'(data_valid), 64'(0));

        // random traffic with varying valid density and error rate
        for (int phase = 0; phase < 8; phase++) begin
            int p_bad, p_valid;
            p_bad   = (phase % 4 == 0) ? 0 : (phase % 4 == 1) ? 2 : (phase % 4 == 2) ? 20 : 60;
            p_valid = (phase < 4) ? 100 : 70;
            for (int i = 0; i < 400; i++) begin
                bit v;
                v = ($urandom_range(1, 100) <= p_valid);
                if ($urandom_range(0, 999) == 0) step(0, v, good_hdr());
                else step(1, v, ($urandom_range(1, 100) <= p_bad) ? bad_hdr() : good_hdr());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
